// File: rtl/collision_scheduler_pkg.sv
// Shared widths and FSM encoding for the frame collision scheduler.
// Imported by the scheduler top and by its box-overlap checker.
package collision_defs;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int SIZE_W = 10;

  // Wide enough for coordinate + size without wrapping.
  localparam int SUM_W  = ((X_W > Y_W) ? ((X_W > SIZE_W) ? X_W : SIZE_W)
                                       : ((Y_W > SIZE_W) ? Y_W : SIZE_W)) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/collision_scheduler_chk.sv
// Combinational axis-aligned box overlap test between two square boxes of edge size.
// Boxes that only touch along an edge do not collide.
module imagecollision
  import collision_defs::*;
(
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y1,
  input  logic [X_W-1:0]    x2,
  input  logic [Y_W-1:0]    y2,
  input  logic [SIZE_W-1:0] size,
  output logic              collision
);

  logic [SUM_W-1:0] x1_e;
  logic [SUM_W-1:0] y1_e;
  logic [SUM_W-1:0] x2_e;
  logic [SUM_W-1:0] y2_e;
  logic [SUM_W-1:0] size_e;
  logic             overlap_x;
  logic             overlap_y;

  assign x1_e   = SUM_W'(x1);
  assign y1_e   = SUM_W'(y1);
  assign x2_e   = SUM_W'(x2);
  assign y2_e   = SUM_W'(y2);
  assign size_e = SUM_W'(size);

  assign overlap_x = (x1_e < x2_e + size_e) && (x2_e < x1_e + size_e);
  assign overlap_y = (y1_e < y2_e + size_e) && (y2_e < y1_e + size_e);

  assign collision = overlap_x && overlap_y;

endmodule

// File: rtl/collision_scheduler.sv
// Once per start pulse, walks every object slot through one shared box checker
// and commits a stable per-slot hit vector with its popcount.
module collision_scheduler
  import collision_defs::*;
#(
  parameter int NUM_OBJ  = 8,
  parameter int IDX_W    = 3,
  parameter int OBJ_SIZE = 50
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [X_W-1:0]         sword_x,
  input  logic [Y_W-1:0]         sword_y,
  input  logic [NUM_OBJ-1:0]     obj_valid,
  input  logic [NUM_OBJ*X_W-1:0] obj_x,
  input  logic [NUM_OBJ*Y_W-1:0] obj_y,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_OBJ-1:0]     hit_vec,
  output logic                   hit_any,
  output logic [IDX_W:0]         hit_count,
  output logic                   overrun
);

  localparam logic [SIZE_W-1:0] SIZE_VAL = SIZE_W'(OBJ_SIZE);
  localparam logic [IDX_W:0]    IDX_END  = (IDX_W+1)'(NUM_OBJ);

  function automatic logic [IDX_W:0] popcount(input logic [NUM_OBJ-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      c = c + (IDX_W+1)'(v[i]);
    end
    return c;
  endfunction

  state_t               state;
  state_t               state_next;
  logic [IDX_W:0]       idx;
  logic [IDX_W:0]       idx_inc;
  logic [X_W-1:0]       sword_x_snap;
  logic [Y_W-1:0]       sword_y_snap;
  logic [NUM_OBJ-1:0]   valid_snap;
  logic [NUM_OBJ-1:0]   work;
  logic [NUM_OBJ-1:0]   work_next;
  logic [X_W-1:0]       op_x2;
  logic [Y_W-1:0]       op_y2;
  logic [IDX_W-1:0]     op_idx;
  logic                 op_vld;
  logic                 collision;
  logic                 accept;
  logic                 load_en;
  logic                 commit;

  logic [X_W-1:0] obj_x_arr [NUM_OBJ];
  logic [Y_W-1:0] obj_y_arr [NUM_OBJ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_unpack
      assign obj_x_arr[gi] = obj_x[gi*X_W +: X_W];
      assign obj_y_arr[gi] = obj_y[gi*Y_W +: Y_W];
    end
  endgenerate

  assign idx_inc = idx + 1'b1;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx_inc == IDX_END) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = 1'b0;
    accept  = 1'b0;
    load_en = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE:    accept  = start;
      SCAN:    begin busy = 1'b1; load_en = 1'b1; end
      DRAIN:   begin busy = 1'b1; commit  = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  imagecollision u_chk (
    .x1        (sword_x_snap),
    .y1        (sword_y_snap),
    .x2        (op_x2),
    .y2        (op_y2),
    .size      (SIZE_VAL),
    .collision (collision)
  );

  // The result of the operand pair loaded last edge lands in its slot here,
  // so the commit in DRAIN sees the final slot without an extra cycle.
  always_comb begin
    work_next = work;
    if (op_vld) begin
      work_next[op_idx] = collision & valid_snap[op_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      sword_x_snap <= '0;
      sword_y_snap <= '0;
      valid_snap   <= '0;
      work         <= '0;
      op_x2        <= '0;
      op_y2        <= '0;
      op_idx       <= '0;
      op_vld       <= 1'b0;
      hit_vec      <= '0;
      hit_any      <= 1'b0;
      hit_count    <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      op_vld  <= 1'b0;
      done    <= commit;
      overrun <= start & busy;

      if (accept) begin
        sword_x_snap <= sword_x;
        sword_y_snap <= sword_y;
        valid_snap   <= obj_valid;
        work         <= '0;
        idx          <= '0;
      end else begin
        work <= work_next;
      end

      if (load_en) begin
        op_x2  <= obj_x_arr[idx[IDX_W-1:0]];
        op_y2  <= obj_y_arr[idx[IDX_W-1:0]];
        op_idx <= idx[IDX_W-1:0];
        op_vld <= 1'b1;
        idx    <= idx_inc;
      end

      if (commit) begin
        hit_vec   <= work_next;
        hit_any   <= |work_next;
        hit_count <= popcount(work_next);
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: a vector table of whole-frame scans plus
// hand-written reset, overrun and back-to-back sequences.
module tb_collision_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  sword_x = '0;
  logic [8:0]  sword_y = '0;
  logic [7:0]  obj_valid = '0;
  logic [79:0] obj_x = '0;
  logic [71:0] obj_y = '0;
  logic        busy;
  logic        done;
  logic [7:0]  hit_vec;
  logic        hit_any;
  logic [3:0]  hit_count;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  collision_scheduler #(.NUM_OBJ(8), .IDX_W(3), .OBJ_SIZE(50)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .sword_x   (sword_x),
    .sword_y   (sword_y),
    .obj_valid (obj_valid),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .busy      (busy),
    .done      (done),
    .hit_vec   (hit_vec),
    .hit_any   (hit_any),
    .hit_count (hit_count),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic [7:0]  valid;
    logic [79:0] ox;
    logic [71:0] oy;
    logic [7:0]  exp_hit;
    logic [3:0]  exp_cnt;
    logic        exp_any;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sword_x   = v.sx;
    sword_y   = v.sy;
    obj_valid = v.valid;
    obj_x     = v.ox;
    obj_y     = v.oy;
  endtask

  // Pulse start for one edge; returns just after that edge (E0).
  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from just after E0 until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " hit_vec"},   32'(hit_vec),   32'(v.exp_hit));
    check({tag, " hit_count"}, 32'(hit_count), 32'(v.exp_cnt));
    check({tag, " hit_any"},   32'(hit_any),   32'(v.exp_any));
    check({tag, " busy_in_done"}, 32'(busy),   32'd0);
  endtask

  initial begin
    int   lat;
    int   n_done;
    vec_t prev;

    // slot0 hit, rest far away
    vecs[0] = '{10'd50, 9'd50, 8'h01, {{7{10'd400}}, 10'd60}, {{7{9'd300}}, 9'd60}, 8'h01, 4'd1, 1'b1};
    // nothing valid, all would collide
    vecs[1] = '{10'd50, 9'd50, 8'h00, {8{10'd60}}, {8{9'd60}}, 8'h00, 4'd0, 1'b0};
    // everything hits, including slot 7
    vecs[2] = '{10'd50, 9'd50, 8'hFF, {8{10'd55}}, {8{9'd55}}, 8'hFF, 4'd8, 1'b1};
    // edge-touching boxes miss, one-pixel overlaps hit
    vecs[3] = '{10'd50, 9'd50, 8'hFF,
                {10'd99, 10'd50, 10'd60, 10'd0, 10'd1, 10'd60, 10'd100, 10'd99},
                {9'd1, 9'd50, 9'd0, 9'd60, 9'd1, 9'd100, 9'd60, 9'd99},
                8'hC9, 4'd4, 1'b1};
    // same geometry, partial valid mask
    vecs[4] = '{10'd50, 9'd50, 8'h5A,
                {10'd99, 10'd50, 10'd60, 10'd0, 10'd1, 10'd60, 10'd100, 10'd99},
                {9'd1, 9'd50, 9'd0, 9'd60, 9'd1, 9'd100, 9'd60, 9'd99},
                8'h48, 4'd2, 1'b1};
    // coordinates near full scale: sums must not wrap
    vecs[5] = '{10'd1000, 9'd500, 8'hAA, {8{10'd1023}}, {8{9'd511}}, 8'hAA, 4'd4, 1'b1};

    // Reset state
    tick();
    tick();
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    check("rst hit_vec",   32'(hit_vec),   32'd0);
    check("rst hit_count", 32'(hit_count), 32'd0);
    check("rst overrun",   32'(overrun),   32'd0);
    reset = 1'b0;
    tick();

    // Table: scans run back to back, each start lands in the previous done cycle
    prev = '{default: '0};
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      start_scan();
      check($sformatf("vec%0d busy_after_start", i), 32'(busy), 32'd1);
      check($sformatf("vec%0d held_hit_vec", i), 32'(hit_vec), 32'(prev.exp_hit));
      wait_done(lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      check_result($sformatf("vec%0d", i), vecs[i]);
      $display("vec%0d: valid=%02h hit_vec=%02h count=%0d any=%0d latency=%0d",
               i, vecs[i].valid, hit_vec, hit_count, hit_any, lat);
      prev = vecs[i];
    end
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    // Reset mid-scan discards the scan and clears outputs
    apply(vecs[2]);
    start_scan();
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("midrst busy",    32'(busy),    32'd0);
    check("midrst done",    32'(done),    32'd0);
    check("midrst hit_vec", 32'(hit_vec), 32'd0);
    check("midrst hit_any", 32'(hit_any), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst idle", 32'(busy), 32'd0);
    apply(vecs[0]);
    start_scan();
    wait_done(lat);
    check("postrst latency", 32'(lat), 32'd9);
    check_result("postrst", vecs[0]);
    $display("reset-mid-scan: hit_vec=%02h latency=%0d", hit_vec, lat);
    tick();

    // Overrun: second start while busy is ignored, valid change is not snapshotted
    apply(vecs[3]);
    start_scan();
    tick(); tick();
    obj_valid = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("overrun pulse", 32'(overrun), 32'd1);
    tick();
    check("overrun clears", 32'(overrun), 32'd0);
    n_done = 0;
    lat = 4;
    while (lat < 9) begin
      tick();
      lat++;
      if (done === 1'b1) n_done++;
    end
    check("overrun done_at_9", 32'(done), 32'd1);
    check_result("overrun", vecs[3]);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("overrun done_count", 32'(n_done), 32'd1);
    check("overrun hold", 32'(hit_vec), 32'(vecs[3].exp_hit));
    $display("overrun: hit_vec=%02h dones=%0d", hit_vec, n_done);

    // Back-to-back: start in the done cycle is accepted
    apply(vecs[5]);
    start_scan();
    wait_done(lat);
    check("b2b first latency", 32'(lat), 32'd9);
    apply(vecs[4]);
    start_scan();
    check("b2b busy",      32'(busy),    32'd1);
    check("b2b done_low",  32'(done),    32'd0);
    check("b2b held",      32'(hit_vec), 32'(vecs[5].exp_hit));
    wait_done(lat);
    check("b2b second latency", 32'(lat), 32'd9);
    check_result("b2b", vecs[4]);
    $display("back-to-back: hit_vec=%02h count=%0d latency=%0d", hit_vec, hit_count, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
